// File: rtl/res_pipe.sv
// Three-stage modular subtractor res = dataS - dataA (mod 2^WIDTH), split into low/high halves.
// Define RES_PIPE_BORROW_EN to add the borrow_dd output (dataS < dataA as unsigned).
module res_pipe #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] dataS,
  input  logic [WIDTH-1:0] dataA,
  output logic             valid_out,
  output logic [IDX_W-1:0] idx_dd,
  output logic [WIDTH-1:0] res_dd
`ifdef RES_PIPE_BORROW_EN
  ,
  output logic             borrow_dd
`endif
);

  localparam int H = WIDTH / 2;
`ifdef RES_PIPE_BORROW_EN
  localparam int HD = H + 1;
`else
  // Without the borrow output the high-half borrow bit has no consumer.
  localparam int HD = H;
`endif

  logic [H:0]       lo_diff;
  logic [HD-1:0]    hi_diff;

  logic             v1_q, v1_d;
  logic [H-1:0]     lo1_q, lo1_d;
  logic             brw1_q, brw1_d;
  logic [H-1:0]     s_hi1_q, s_hi1_d;
  logic [H-1:0]     a_hi1_q, a_hi1_d;
  logic [IDX_W-1:0] idx1_q, idx1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic [IDX_W-1:0] idx2_q, idx2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] res3_q, res3_d;
  logic [IDX_W-1:0] idx3_q, idx3_d;

`ifdef RES_PIPE_BORROW_EN
  logic             brw2_q, brw2_d;
  logic             brw3_q, brw3_d;
`endif

  always_comb begin
    // Top bit of the (H+1)-bit difference is the borrow out of the low half.
    lo_diff  = {1'b0, dataS[H-1:0]} - {1'b0, dataA[H-1:0]};
    v1_d     = valid_in;
    lo1_d    = lo1_q;
    brw1_d   = brw1_q;
    s_hi1_d  = s_hi1_q;
    a_hi1_d  = a_hi1_q;
    idx1_d   = idx1_q;
    if (valid_in) begin
      lo1_d   = lo_diff[H-1:0];
      brw1_d  = lo_diff[H];
      s_hi1_d = dataS[WIDTH-1:H];
      a_hi1_d = dataA[WIDTH-1:H];
      idx1_d  = idx;
    end
  end

  always_comb begin
    hi_diff = HD'(s_hi1_q) - HD'(a_hi1_q) - HD'(brw1_q);
    v2_d    = v1_q;
    res2_d  = res2_q;
    idx2_d  = idx2_q;
`ifdef RES_PIPE_BORROW_EN
    brw2_d  = brw2_q;
`endif
    if (v1_q) begin
      res2_d = {hi_diff[H-1:0], lo1_q};
      idx2_d = idx1_q;
`ifdef RES_PIPE_BORROW_EN
      brw2_d = hi_diff[H];
`endif
    end
  end

  always_comb begin
    v3_d   = v2_q;
    res3_d = res3_q;
    idx3_d = idx3_q;
`ifdef RES_PIPE_BORROW_EN
    brw3_d = brw3_q;
`endif
    if (v2_q) begin
      res3_d = res2_q;
      idx3_d = idx2_q;
`ifdef RES_PIPE_BORROW_EN
      brw3_d = brw2_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      v1_q    <= 1'b0;
      lo1_q   <= '0;
      brw1_q  <= 1'b0;
      s_hi1_q <= '0;
      a_hi1_q <= '0;
      idx1_q  <= '0;
      v2_q    <= 1'b0;
      res2_q  <= '0;
      idx2_q  <= '0;
      v3_q    <= 1'b0;
      res3_q  <= '0;
      idx3_q  <= '0;
`ifdef RES_PIPE_BORROW_EN
      brw2_q  <= 1'b0;
      brw3_q  <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      lo1_q   <= lo1_d;
      brw1_q  <= brw1_d;
      s_hi1_q <= s_hi1_d;
      a_hi1_q <= a_hi1_d;
      idx1_q  <= idx1_d;
      v2_q    <= v2_d;
      res2_q  <= res2_d;
      idx2_q  <= idx2_d;
      v3_q    <= v3_d;
      res3_q  <= res3_d;
      idx3_q  <= idx3_d;
`ifdef RES_PIPE_BORROW_EN
      brw2_q  <= brw2_d;
      brw3_q  <= brw3_d;
`endif
    end
  end

  assign valid_out = v3_q;
  assign idx_dd    = idx3_q;
  assign res_dd    = res3_q;
`ifdef RES_PIPE_BORROW_EN
  assign borrow_dd = brw3_q;
`endif

endmodule

// File: tb/tb_res_pipe.sv
// Randomized and directed bench for res_pipe (WIDTH=4, IDX_W=4) against a latency/queue reference model.
// Borrow checks are compiled in only when RES_PIPE_BORROW_EN is defined.
module tb_res_pipe;
  logic       clk;
  logic       reset_L;
  logic       valid_in;
  logic [3:0] idx;
  logic [3:0] dataS;
  logic [3:0] dataA;
  logic       valid_out;
  logic [3:0] idx_dd;
  logic [3:0] res_dd;
`ifdef RES_PIPE_BORROW_EN
  logic       borrow_dd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] idx;
    logic [3:0] res;
    logic       brw;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] b_q[$];
  logic [3:0] hold_idx, hold_res;
  logic       hold_brw;

  res_pipe #(.WIDTH(4), .IDX_W(4)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .idx       (idx),
    .dataS     (dataS),
    .dataA     (dataA),
    .valid_out (valid_out),
    .idx_dd    (idx_dd),
    .res_dd    (res_dd)
`ifdef RES_PIPE_BORROW_EN
    ,
    .borrow_dd (borrow_dd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h required=0x%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Output expected now is whatever was sampled two edges earlier; data holds across bubbles.
  task automatic check_outputs(input string tag);
    exp_t e;
    e = '0;
    if (exp_q.size() >= 3) e = exp_q[exp_q.size() - 3];
    if (e.v) begin
      hold_idx = e.idx;
      hold_res = e.res;
      hold_brw = e.brw;
    end
    chk({tag, "_valid"}, valid_out, e.v);
    chk({tag, "_idx"},   idx_dd,    hold_idx);
    chk({tag, "_res"},   res_dd,    hold_res);
`ifdef RES_PIPE_BORROW_EN
    chk({tag, "_borrow"}, borrow_dd, hold_brw);
`endif
    $display("cycle %s: valid_out=%0b idx_dd=0x%0h res_dd=0x%0h", tag, valid_out, idx_dd, res_dd);
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] id,
                      input logic [3:0] s, input logic [3:0] a);
    exp_t e;
    valid_in = v;
    idx      = id;
    dataS    = s;
    dataA    = a;
    @(posedge clk);
    e.v   = v;
    e.idx = id;
    e.res = 4'(s - a);
    e.brw = (s < a);
    exp_q.push_back(e);
    if (exp_q.size() > 3) void'(exp_q.pop_front());
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_idx = '0;
    hold_res = '0;
    hold_brw = 1'b0;
  endtask

  task automatic rt_pop();
    if (valid_out) begin
      if (b_q.size() == 0) chk("rt_unexpected_valid", 32'd1, 32'd0);
      else chk("roundtrip", res_dd, b_q.pop_front());
    end
  endtask

  initial begin
    logic [3:0] ra, rb;
    int         rt_idx;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    idx      = '0;
    dataS    = '0;
    dataA    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", valid_out, 0);
    chk("reset_idx",   idx_dd,    0);
    chk("reset_res",   res_dd,    0);
    reset_L = 1'b1;

    // Basic subtraction 9-3
    step("basic", 1'b1, 4'h1, 4'h9, 4'h3);
    idle(2);
    chk("basic_res_const", res_dd, 32'h6);
    idle(1);
    chk("basic_valid_drop", valid_out, 0);

    // Low-half borrow absorbed by the high half, then wrap-around
    step("lo_borrow", 1'b1, 4'h2, 4'h4, 4'h1);
    step("wrap", 1'b1, 4'h3, 4'h2, 4'h5);
    idle(1);
    chk("lo_borrow_res_const", res_dd, 32'h3);
    idle(1);
    chk("wrap_res_const", res_dd, 32'hD);
`ifdef RES_PIPE_BORROW_EN
    chk("wrap_borrow_const", borrow_dd, 1);
`endif

    // Full stream
    for (int i = 0; i < 4; i++) step("stream", 1'b1, 4'(i), 4'hF, 4'(i));
    idle(4);

    // Bubble between two words
    step("bubble_a", 1'b1, 4'h5, 4'h8, 4'h1);
    step("bubble_gap", 1'b0, 4'hA, 4'hA, 4'hA);
    step("bubble_b", 1'b1, 4'h6, 4'h8, 4'h2);
    idle(3);

    // Reset mid-flight: two words in the pipe, then asynchronous reset between edges
    step("inflight_a", 1'b1, 4'h7, 4'hC, 4'h1);
    step("inflight_b", 1'b1, 4'h8, 4'hB, 4'h2);
    #2 reset_L = 1'b0;
    #1;
    chk("rst_async_valid", valid_out, 0);
    chk("rst_async_idx",   idx_dd,    0);
    chk("rst_async_res",   res_dd,    0);
`ifdef RES_PIPE_BORROW_EN
    chk("rst_async_borrow", borrow_dd, 0);
`endif
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    idle(3);
    step("post_rst", 1'b1, 4'h9, 4'h7, 4'h3);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));
    idle(3);

    // Round trip: dataS = A+B, dataA = A must give back B
    rt_idx = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ra = 4'(a);
        rb = 4'(b);
        b_q.push_back(rb);
        step("rt", 1'b1, 4'(rt_idx), 4'(ra + rb), ra);
        rt_pop();
        rt_idx++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      step("rt_flush", 1'b0, 4'h0, 4'h0, 4'h0);
      rt_pop();
    end
    chk("rt_drained", b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/res_pipe.md
Name: res_pipe

Overview:
- Pipelined modular subtractor, the inverse of the team's split-carry sum pipeline.
- Takes a sum word `dataS` and one operand `dataA`, and recovers the other operand: `res = dataS - dataA` (mod 2^WIDTH).
  - Low half is computed first; the borrow goes into the high half one stage later.
  - Result passes through an output register.
- Sits after the sum pipeline in the arithmetic test chain, tagged with the same `idx`, for round-trip checking.

Parameters:
- WIDTH, 4, data width in bits. Must be even and >= 2. Low half is bits [WIDTH/2-1:0]; high half is bits [WIDTH-1:WIDTH/2].
- IDX_W, 4, width of the transaction tag carried alongside the data.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous active-low reset. Assertion clears all state immediately; deassertion is sampled on clk.
- valid_in  input  1  input word valid this cycle.
- idx  input  IDX_W  transaction tag.
- dataS  input  WIDTH  minuend (sum word).
- dataA  input  WIDTH  subtrahend (known operand).
- valid_out  output  1  res_dd/idx_dd carry a valid result.
- idx_dd  output  IDX_W  tag of the result on res_dd.
- res_dd  output  WIDTH  dataS - dataA mod 2^WIDTH.
- borrow_dd  output  1  final borrow out of the MSB. Present only with RES_PIPE_BORROW_EN.

Behaviour:
- Reset (reset_L=0, asynchronous): every pipeline register and every output goes to 0.
  - valid_out=0, idx_dd=0, res_dd=0, borrow_dd=0.
  - Reset mid-operation discards all in-flight words; nothing emerges after release until new valid_in.
- Stage 1, edge n, sampling inputs:
  - lo1 <= dataS_lo - dataA_lo, computed at WIDTH/2+1 bits.
  - brw1 <= 1 iff dataS_lo < dataA_lo.
  - S_hi1/A_hi1 <= high halves.
  - idx1 <= idx; v1 <= valid_in.
- Stage 2, edge n+1:
  - hi2 <= S_hi1 - A_hi1 - brw1, computed at WIDTH/2+1 bits.
  - res2 <= {hi2[WIDTH/2-1:0], lo1[WIDTH/2-1:0]}.
  - brw2 <= 1 iff S_hi1 < A_hi1 + brw1.
  - idx2, v2 forwarded.
- Stage 3, edge n+2: res_dd <= res2; idx_dd <= idx2; valid_out <= v2; borrow_dd <= brw2.
- Latency: a word sampled at edge n is visible on the outputs after edge n+2, i.e. 3 register stages. Throughput is one word per cycle.
- No backpressure: downstream must accept every cycle valid_out=1.
- Bubbles:
  - Valid bits always advance.
  - Data/idx registers of a stage load only when the incoming valid is 1; otherwise they hold.
  - So res_dd/idx_dd hold the last valid result while valid_out=0.
- Arithmetic is modulo 2^WIDTH; wrap-around is legal, not an error.
- Round-trip invariant: res_pipe(dataS = A+B mod 2^WIDTH, dataA = A) == B for all A, B.
- Simultaneous events: the reset edge overrides any valid_in on the same cycle. Back-to-back valid words never interact except through their own borrow path.

Optional Feature:
- RES_PIPE_BORROW_EN
- Defined:
  - borrow_dd port exists and tracks the pipeline as above.
  - borrow_dd=1 flags dataS < dataA as unsigned WIDTH-bit values.
  - borrow_dd follows the same hold-on-bubble rule as res_dd.
- Undefined: the port and the brw2/borrow_dd registers are absent. Results, latency and valid timing are identical.

Test Plan (WIDTH=4, IDX_W=4):
- Basic subtraction:
  - Stimulus: reset, then valid_in=1, dataS=0x9, dataA=0x3, idx=0x1 at edge 0.
  - Response: after edge 2, valid_out=1, res_dd=0x6, idx_dd=0x1, borrow_dd=0. valid_out=0 on the following cycle.
- Low-half borrow:
  - Stimulus: dataS=0x4, dataA=0x1.
  - Response: res_dd=0x3; the high half absorbed the borrow; borrow_dd=0.
- Wrap-around:
  - Stimulus: dataS=0x2, dataA=0x5.
  - Response: res_dd=0xD, borrow_dd=1.
- Full stream:
  - Stimulus: 4 consecutive valid words, idx 0..3, dataS=0xF, dataA=0x0..0x3.
  - Response: valid_out=1 on 4 consecutive cycles starting after edge 2; res_dd 0xF, 0xE, 0xD, 0xC in idx order.
- Bubble:
  - Stimulus: valid words at edges 0 and 2, valid_in=0 at edge 1.
  - Response: valid_out pattern 1, 0, 1; res_dd/idx_dd hold the first result during the 0 cycle.
- Reset mid-flight:
  - Stimulus: two words in flight, reset_L=0 asynchronously between edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge. No valid_out after release until a new valid_in, then a result 3 edges later.
- Round-trip sweep: all 256 (A, B) pairs driven through sum pipeline then res_pipe -> res_dd==B with matching idx.
